pe_mac_stream: RTL and testbench

//  Second-generation systolic PE: signed fixed-point multiply-accumulate over a programmable number of

---
 rtl/pe_mac_stream.sv | 117 +++++++++++
 tb/tb_pe_mac_stream.sv | 229 ++++++++++++++++++++++
 2 files changed

// File: rtl/pe_mac_stream.sv
// Systolic PE: signed fixed-point MAC over a latched number of valid pairs, then a one-cycle drain onto o_out.
// Build option PE_SAT_EN: saturate the scaled result to WIDTH bits (otherwise truncate/wrap).
module pe_mac_stream #(
   parameter int WIDTH     = 8,
   parameter int DECIMAL   = 4,
   parameter int ACC_WIDTH = 20,
   parameter int LEN_W     = 8
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             start,
   input  logic [LEN_W-1:0] len,
   input  logic             i_valid,
   input  logic [WIDTH-1:0] i_in,
   input  logic [WIDTH-1:0] i_w,
   input  logic             i_out_valid,
   input  logic [WIDTH-1:0] i_out,
   output logic             o_valid,
   output logic [WIDTH-1:0] o_in,
   output logic [WIDTH-1:0] o_w,
   output logic             o_out_valid,
   output logic [WIDTH-1:0] o_out,
   output logic             busy,
   output logic             done,
   output logic             o_collide,
   output logic [1:0]       o_dbg_state
);

   typedef enum logic [1:0] {
      S_IDLE  = 2'd0,
      S_ACC   = 2'd1,
      S_DRAIN = 2'd2
   } state_t;

   localparam logic signed [ACC_WIDTH-1:0] SAT_MAX = ACC_WIDTH'((1 << (WIDTH-1)) - 1);
   localparam logic signed [ACC_WIDTH-1:0] SAT_MIN = ACC_WIDTH'(-(1 << (WIDTH-1)));

   state_t                        r_state;
   logic signed [ACC_WIDTH-1:0]   r_acc;
   logic        [LEN_W-1:0]       r_count;
   logic        [LEN_W-1:0]       r_len;

   logic signed [2*WIDTH-1:0]     w_prod;
   logic signed [ACC_WIDTH-1:0]   w_prod_ext;
   logic signed [ACC_WIDTH-1:0]   w_shift;
   logic        [WIDTH-1:0]       w_result;
   logic                          w_last;

   assign w_prod     = $signed(i_in) * $signed(i_w);
   assign w_prod_ext = ACC_WIDTH'(w_prod);
   assign w_shift    = r_acc >>> DECIMAL;
   assign w_last     = (r_count == r_len - LEN_W'(1));

`ifdef PE_SAT_EN
   always_comb begin
      w_result = w_shift[WIDTH-1:0];
      if (w_shift > SAT_MAX)
         w_result = SAT_MAX[WIDTH-1:0];
      else if (w_shift < SAT_MIN)
         w_result = SAT_MIN[WIDTH-1:0];
   end
`else
   assign w_result = w_shift[WIDTH-1:0];
`endif

   // Status decodes come straight off the state register; collision reflects the upstream valid seen in DRAIN.
   assign busy        = (r_state == S_ACC) || (r_state == S_DRAIN);
   assign done        = (r_state == S_DRAIN);
   assign o_collide   = (r_state == S_DRAIN) && i_out_valid;
   assign o_dbg_state = r_state;

   always_ff @(posedge clk) begin
      if (!rst) begin
         r_state     <= S_IDLE;
         r_acc       <= '0;
         r_count     <= '0;
         r_len       <= '0;
         o_valid     <= 1'b0;
         o_in        <= '0;
         o_w         <= '0;
         o_out_valid <= 1'b0;
         o_out       <= '0;
      end else begin
         o_valid     <= i_valid;
         o_in        <= i_in;
         o_w         <= i_w;
         o_out_valid <= i_out_valid;
         o_out       <= i_out;
         case (r_state)
            S_IDLE: begin
               if (start) begin
                  r_len   <= len;
                  r_acc   <= '0;
                  r_count <= '0;
                  r_state <= (len == '0) ? S_DRAIN : S_ACC;
               end
            end
            S_ACC: begin
               if (i_valid) begin
                  r_acc   <= r_acc + w_prod_ext;
                  r_count <= r_count + LEN_W'(1);
                  if (w_last)
                     r_state <= S_DRAIN;
               end
            end
            S_DRAIN: begin
               // Own result wins over upstream traffic in this cycle.
               o_out       <= w_result;
               o_out_valid <= 1'b1;
               r_state     <= S_IDLE;
            end
            default: r_state <= S_IDLE;
         endcase
      end
   end

endmodule

// File: tb/tb_pe_mac_stream.sv
// Randomized scoreboard bench for pe_mac_stream with an arithmetic reference model.
`timescale 1ns/1ps
module tb_pe_mac_stream;
   localparam int WIDTH     = 8;
   localparam int DECIMAL   = 4;
   localparam int ACC_WIDTH = 20;
   localparam int LEN_W     = 8;

   logic             clk = 1'b0;
   logic             rst = 1'b0;
   logic             start = 1'b0;
   logic [LEN_W-1:0] len = '0;
   logic             i_valid = 1'b0;
   logic [WIDTH-1:0] i_in = '0;
   logic [WIDTH-1:0] i_w = '0;
   logic             i_out_valid = 1'b0;
   logic [WIDTH-1:0] i_out = '0;
   logic             o_valid;
   logic [WIDTH-1:0] o_in;
   logic [WIDTH-1:0] o_w;
   logic             o_out_valid;
   logic [WIDTH-1:0] o_out;
   logic             busy;
   logic             done;
   logic             o_collide;
   logic [1:0]       o_dbg_state;

   pe_mac_stream #(.WIDTH(WIDTH), .DECIMAL(DECIMAL), .ACC_WIDTH(ACC_WIDTH), .LEN_W(LEN_W)) dut (
      .clk(clk), .rst(rst), .start(start), .len(len),
      .i_valid(i_valid), .i_in(i_in), .i_w(i_w),
      .i_out_valid(i_out_valid), .i_out(i_out),
      .o_valid(o_valid), .o_in(o_in), .o_w(o_w),
      .o_out_valid(o_out_valid), .o_out(o_out),
      .busy(busy), .done(done), .o_collide(o_collide), .o_dbg_state(o_dbg_state)
   );

   // clock / reset
   always #5 clk = ~clk;

   int cyc = 0;
   always @(posedge clk) cyc <= cyc + 1;

   // scoreboard state
   logic [WIDTH-1:0] exp_q[$];
   int               done_q[$];
   int               coll_q[$];
   logic [WIDTH-1:0] pa[64];
   logic [WIDTH-1:0] pb[64];
   int               n_pass = 0;
   int               n_total = 0;
   bit               mon_en = 1'b0;

   task automatic chk(input bit ok, input string name, input int act, input int req);
      n_total++;
      if (ok) n_pass++;
      else $display("FAIL %s at cycle %0d: got 0x%0h, want 0x%0h", name, cyc, act, req);
   endtask

   // reference model: sum of signed products, wrapped to ACC_WIDTH, scaled and reduced
   function automatic logic [WIDTH-1:0] model(input int n);
      longint s = 0;
      longint r;
      for (int i = 0; i < n; i++)
         s += longint'($signed(pa[i])) * longint'($signed(pb[i]));
      s = s & ((64'sd1 << ACC_WIDTH) - 1);
      if (s >= (64'sd1 << (ACC_WIDTH-1))) s -= (64'sd1 << ACC_WIDTH);
      r = s >>> DECIMAL;
`ifdef PE_SAT_EN
      if (r > 127) r = 127;
      if (r < -128) r = -128;
`endif
      return r[WIDTH-1:0];
   endfunction

   // monitor
   logic             p_rst = 1'b0;
   logic             p_valid;
   logic [WIDTH-1:0] p_in, p_w;
   always @(posedge clk) begin
      p_rst   <= rst;
      p_valid <= i_valid;
      p_in    <= i_in;
      p_w     <= i_w;
   end

   always @(negedge clk) begin
      if (mon_en) begin
         if (!p_rst) begin
            chk({o_valid, o_in, o_w, o_out_valid, o_out, busy, done, o_collide} == '0,
                "reset_zero", {o_valid, o_out_valid, busy, done, o_collide}, 0);
         end else begin
            chk(o_valid == p_valid, "pass_valid", o_valid, p_valid);
            chk(o_in == p_in && o_w == p_w, "pass_data", {o_in, o_w}, {p_in, p_w});
            if (o_out_valid) begin
               if (exp_q.size() == 0) chk(1'b0, "out_unexpected", o_out, 0);
               else begin
                  logic [WIDTH-1:0] e;
                  e = exp_q.pop_front();
                  chk(o_out == e, "out_value", o_out, e);
               end
            end
            if (done_q.size() > 0 && done_q[0] < cyc) begin
               chk(1'b0, "done_missing", 0, 1);
               void'(done_q.pop_front());
            end
            if (done) begin
               chk(busy == 1'b1, "busy_in_drain", busy, 1);
               if (done_q.size() > 0 && done_q[0] == cyc) begin
                  chk(1'b1, "done_time", cyc, done_q[0]);
                  void'(done_q.pop_front());
               end else chk(1'b0, "done_unexpected", 1, 0);
            end
            if (coll_q.size() > 0 && coll_q[0] < cyc) begin
               chk(1'b0, "collide_missing", 0, 1);
               void'(coll_q.pop_front());
            end
            if (o_collide) begin
               if (coll_q.size() > 0 && coll_q[0] == cyc) begin
                  chk(1'b1, "collide_time", cyc, coll_q[0]);
                  void'(coll_q.pop_front());
               end else chk(1'b0, "collide_unexpected", 1, 0);
            end
         end
      end
   end

   // driver: present one cycle of inputs, record expectations, advance one clock
   task automatic step(input bit st, input int ln, input bit v, input logic [WIDTH-1:0] a,
                       input logic [WIDTH-1:0] b, input bit ov, input logic [WIDTH-1:0] ou,
                       input bit drain, input bit own_en, input logic [WIDTH-1:0] own);
      start = st; len = LEN_W'(ln); i_valid = v; i_in = a; i_w = b;
      i_out_valid = ov; i_out = ou;
      if (ov && !drain) exp_q.push_back(ou);
      if (ov && drain) coll_q.push_back(cyc);
      if (own_en) begin
         exp_q.push_back(own);
         done_q.push_back(cyc + 1);
      end
      @(posedge clk); #1;
   endtask

   function automatic bit rbit(input bit en);
      return en && ($urandom_range(0, 1) == 1);
   endfunction

   function automatic logic [WIDTH-1:0] rbyte();
      return WIDTH'($urandom_range(0, 255));
   endfunction

   task automatic run_job(input int n, input bit gaps, input bit collide, input bit traffic,
                          input bit noise);
      logic [WIDTH-1:0] r;
      r = model(n);
      // operands alongside start must not be accumulated
      step(1'b1, n, 1'b1, rbyte(), rbyte(), rbit(traffic), rbyte(), 1'b0, n == 0, r);
      for (int i = 0; i < n; i++) begin
         if (gaps) begin
            repeat ($urandom_range(0, 2))
               step(rbit(noise), $urandom_range(0, 5), 1'b0, rbyte(), rbyte(), rbit(traffic),
                    rbyte(), 1'b0, 1'b0, '0);
         end
         step(1'b0, 0, 1'b1, pa[i], pb[i], rbit(traffic), rbyte(), 1'b0, i == n - 1, r);
      end
      step(noise, $urandom_range(0, 5), rbit(1'b1), rbyte(), rbyte(), collide, 8'h55,
           1'b1, 1'b0, '0);
   endtask

   task automatic idle(input int cycles, input bit traffic);
      repeat (cycles)
         step(1'b0, 0, rbit(1'b1), rbyte(), rbyte(), rbit(traffic), rbyte(), 1'b0, 1'b0, '0);
   endtask

   initial begin
      @(posedge clk); #1;
      mon_en = 1'b1;
      repeat (2) begin @(posedge clk); #1; end
      rst = 1'b1;
      idle(2, 1'b0);

      // single product: 2.0 * 1.5 = 3.0
      pa[0] = 8'h20; pb[0] = 8'h18;
      run_job(1, 1'b0, 1'b0, 1'b0, 1'b0);
      // three products with stalls: 9.0 overflows WIDTH
      for (int i = 0; i < 3; i++) begin pa[i] = 8'h20; pb[i] = 8'h18; end
      run_job(3, 1'b1, 1'b0, 1'b0, 1'b0);
      // negative accumulation: -1.0 * 2.0 twice
      for (int i = 0; i < 2; i++) begin pa[i] = 8'hF0; pb[i] = 8'h20; end
      run_job(2, 1'b0, 1'b0, 1'b0, 1'b0);
      // upstream value in IDLE forwarded, then collision during DRAIN
      step(1'b0, 0, 1'b0, '0, '0, 1'b1, 8'h55, 1'b0, 1'b0, '0);
      pa[0] = 8'h10; pb[0] = 8'h30;
      run_job(1, 1'b0, 1'b1, 1'b0, 1'b0);
      // zero-length job, with a colliding upstream value
      run_job(0, 1'b0, 1'b1, 1'b0, 1'b0);
      // start during ACC and DRAIN ignored
      for (int i = 0; i < 4; i++) begin pa[i] = rbyte(); pb[i] = rbyte(); end
      run_job(4, 1'b1, 1'b0, 1'b1, 1'b1);

      // reset mid-ACC after one of three products: no drain, no done
      step(1'b1, 3, 1'b0, '0, '0, 1'b0, '0, 1'b0, 1'b0, '0);
      step(1'b0, 0, 1'b1, 8'h40, 8'h40, 1'b0, '0, 1'b0, 1'b0, '0);
      rst = 1'b0;
      step(1'b0, 0, 1'b1, 8'h33, 8'h44, 1'b0, '0, 1'b0, 1'b0, '0);
      rst = 1'b1;
      for (int i = 0; i < 3; i++) begin pa[i] = 8'h10; pb[i] = 8'h10; end
      run_job(3, 1'b1, 1'b0, 1'b0, 1'b0);

      // accumulator wrap: 40 * (-128 * 127)
      for (int i = 0; i < 40; i++) begin pa[i] = 8'h80; pb[i] = 8'h7F; end
      run_job(40, 1'b0, 1'b0, 1'b0, 1'b0);

      // randomized jobs, back-to-back or separated
      for (int j = 0; j < 30; j++) begin
         int n;
         n = $urandom_range(0, 6);
         for (int i = 0; i < n; i++) begin pa[i] = rbyte(); pb[i] = rbyte(); end
         run_job(n, rbit(1'b1), rbit(1'b1), rbit(1'b1), rbit(1'b1));
         if (rbit(1'b1)) idle($urandom_range(1, 3), 1'b1);
      end

      idle(4, 1'b0);
      chk(exp_q.size() == 0, "out_queue_drained", exp_q.size(), 0);
      chk(done_q.size() == 0, "done_queue_drained", done_q.size(), 0);
      chk(coll_q.size() == 0, "collide_queue_drained", coll_q.size(), 0);
      $display("%0d/%0d checks passed", n_pass, n_total);
      $finish;
   end

endmodule
